// File: rtl/vga_ball_display_if.sv
// Signal bundle between the bounce producer and the VGA ball renderer.
// The producer drives the ball position; the renderer drives video timing, colour and the frame tick.
interface vga_ball_display_if;
    logic [9:0]  ball_x;
    logic [8:0]  ball_y;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        video_on;
    logic        frame_tick;

    modport master (
        output ball_x, ball_y,
        input  hsync, vsync, rgb, video_on, frame_tick
    );

    modport slave (
        input  ball_x, ball_y,
        output hsync, vsync, rgb, video_on, frame_tick
    );
endinterface

// File: rtl/vga_ball_display.sv
// VGA raster generator that draws a walled playfield and a square ball.
// The ball position is latched once per frame, so the ball never tears mid-frame.
module vga_ball_display #(
    parameter int          H_VIS    = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_VIS    = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          BALL_R   = 8,
    parameter int          WALL_W   = 4,
    parameter logic [11:0] BALL_RGB = 12'hF00,
    parameter logic [11:0] WALL_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic               clk,
    input  logic               rst,
    vga_ball_display_if.slave  bus
);

    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] WALL_L     = 10'(WALL_W);
    localparam logic [9:0] WALL_R_X   = 10'(H_VIS - WALL_W);
    localparam logic [9:0] WALL_B_Y   = 10'(V_VIS - WALL_W);
    localparam logic signed [11:0] R_S = 12'(BALL_R);

    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic [9:0]  r_bx;
    logic [8:0]  r_by;
    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_rgb;
    logic        r_video_on;
    logic        r_frame_tick;

    logic [9:0]  w_hc_next;
    logic [9:0]  w_vc_next;
    logic        w_line_end;
    logic        w_latch;
    logic        w_visible;
    logic        w_ball_hit;
    logic        w_wall_hit;
    logic [11:0] w_rgb_next;
    logic signed [11:0] w_hc_s;
    logic signed [11:0] w_vc_s;
    logic signed [11:0] w_bx_s;
    logic signed [11:0] w_by_s;

    assign w_line_end = (r_hc == H_LAST);
    assign w_latch    = w_line_end && (r_vc == V_VIS_LAST);
    assign w_visible  = (r_hc < H_VIS_L) && (r_vc < V_VIS_L);

    // Signed compare so a ball near an edge clips instead of wrapping to the far side.
    assign w_hc_s = signed'({2'b00, r_hc});
    assign w_vc_s = signed'({2'b00, r_vc});
    assign w_bx_s = signed'({2'b00, r_bx});
    assign w_by_s = signed'({3'b000, r_by});

    assign w_ball_hit = (w_hc_s >= w_bx_s - R_S) && (w_hc_s <= w_bx_s + R_S) &&
                        (w_vc_s >= w_by_s - R_S) && (w_vc_s <= w_by_s + R_S);
    assign w_wall_hit = (r_hc < WALL_L) || (r_hc >= WALL_R_X) ||
                        (r_vc < WALL_L) || (r_vc >= WALL_B_Y);

    always_comb begin
        w_hc_next = r_hc + 10'd1;
        w_vc_next = r_vc;
        if (w_line_end) begin
            w_hc_next = 10'd0;
            w_vc_next = (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
        end
    end

    always_comb begin
        w_rgb_next = 12'h000;
        if (w_visible) begin
            if (w_ball_hit)      w_rgb_next = BALL_RGB;
            else if (w_wall_hit) w_rgb_next = WALL_RGB;
            else                 w_rgb_next = BG_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc         <= 10'd0;
            r_vc         <= 10'd0;
            r_bx         <= 10'(H_VIS / 2);
            r_by         <= 9'(V_VIS / 2);
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_rgb        <= 12'h000;
            r_video_on   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_hc         <= w_hc_next;
            r_vc         <= w_vc_next;
            r_hsync      <= !((r_hc >= HS_FIRST) && (r_hc <= HS_LAST));
            r_vsync      <= !((r_vc >= VS_FIRST) && (r_vc <= VS_LAST));
            r_rgb        <= w_rgb_next;
            r_video_on   <= w_visible;
            r_frame_tick <= w_latch;
            if (w_latch) begin
                r_bx <= bus.ball_x;
                r_by <= bus.ball_y;
            end
        end
    end

    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.rgb        = r_rgb;
    assign bus.video_on   = r_video_on;
    assign bus.frame_tick = r_frame_tick;

endmodule
